// File: rtl/dcache_refill_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between MEM and data memory.
// Ports: cpu_* request/response side; mem_* rd_en/wr_en/ready/done block protocol side.
// Define DCACHE_PERF_CNT_EN to add hit_count/miss_count read counters.
module dcache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  input  logic                  mem_done
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_RSP,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_FILL,
    S_RD_RSP,
    S_WR_REQ,
    S_WR_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] buf_d [BLOCK_SIZE];
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [NUM_LINES];
  logic [TAG_W-1:0]      tag_d [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] data_d [NUM_LINES][BLOCK_SIZE];

  logic [IDX_W-1:0]      cpu_idx, cap_idx;
  logic [TAG_W-1:0]      cpu_tag, cap_tag;
  logic [1:0]            cap_off;
  logic                  lookup_hit, cap_hit;
  logic [ADDR_WIDTH-1:0] blk_addr;

  assign cpu_idx    = cpu_addr[2+IDX_W-1:2];
  assign cpu_tag    = cpu_addr[ADDR_WIDTH-1:2+IDX_W];
  assign cap_idx    = addr_q[2+IDX_W-1:2];
  assign cap_tag    = addr_q[ADDR_WIDTH-1:2+IDX_W];
  assign cap_off    = addr_q[1:0];
  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign cap_hit    = valid_q[cap_idx] && (tag_q[cap_idx] == cap_tag);
  assign blk_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a simultaneous read and write resolves to the read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_rd_en)      state_d = lookup_hit ? S_HIT_RSP : S_RD_REQ;
        else if (cpu_wr_en) state_d = S_WR_REQ;
      end
      S_HIT_RSP: state_d = S_IDLE;
      S_RD_REQ:  if (!mem_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_done) state_d = S_RD_FILL;
      S_RD_FILL: if (cnt_q == 2'(BLOCK_SIZE-1)) state_d = S_RD_RSP;
      S_RD_RSP:  state_d = S_IDLE;
      S_WR_REQ:  if (!mem_ready) state_d = S_WR_WAIT;
      S_WR_WAIT: if (mem_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_rd_data = '0;
    cpu_valid   = 1'b0;
    cpu_stall   = (state_q != S_IDLE);
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_address = '0;
    mem_wr_data = '0;
    unique case (state_q)
      S_HIT_RSP: begin
        cpu_rd_data = data_q[cap_idx][cap_off];
        cpu_valid   = 1'b1;
      end
      S_RD_REQ: begin
        mem_rd_en   = 1'b1;
        mem_address = blk_addr;
      end
      S_RD_WAIT: mem_address = blk_addr;
      S_RD_RSP: begin
        cpu_rd_data = buf_q[cap_off];
        cpu_valid   = 1'b1;
      end
      S_WR_REQ: begin
        mem_wr_en   = 1'b1;
        mem_address = addr_q;
        mem_wr_data = wdata_q;
      end
      S_WR_WAIT: begin
        mem_address = addr_q;
        mem_wr_data = wdata_q;
        cpu_valid   = mem_done;
      end
      default: ;
    endcase
  end

  // Datapath next values: request capture, refill buffer, line arrays
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_rd_en || cpu_wr_en) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wr_data;
        end
      end
      S_RD_FILL: begin
        buf_d[cnt_q] = mem_rd_data;
        cnt_d        = cnt_q + 2'd1;
        // Last word: commit the whole block, replacing whatever was there
        if (cnt_q == 2'(BLOCK_SIZE-1)) begin
          data_d[cap_idx]  = buf_d;
          tag_d[cap_idx]   = cap_tag;
          valid_d[cap_idx] = 1'b1;
        end
      end
      S_RD_RSP: cnt_d = '0;
      S_WR_WAIT: begin
        // Write-through: only refresh a resident copy, never allocate
        if (mem_done && cap_hit) data_d[cap_idx][cap_off] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) buf_q[i] <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end

  // Tag and data storage are qualified by valid_q, so they need no reset
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && cpu_rd_en) begin
      if (lookup_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else            miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
